// File: rtl/axi_sram_burst_slave_if.sv
// AXI4 address/data/response channel bundle shared by the SRAM burst slave
// and whatever master drives it. Sideband (clock, reset, SRAM pins) stays on
// the module ports.
interface axi_sram_burst_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // write address
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [3:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  // write data
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  // write response
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  // read address
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [3:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  // read data
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_burst_slave.sv
// AXI4 slave in front of a single-port synchronous SRAM macro. Serves one
// transaction at a time (INCR/FIXED bursts), round-robins between pending
// reads and writes, answers DECERR outside [BASE_ADDR, LIMIT_ADDR] and
// SLVERR for burst-length mismatches and WRAP bursts.
module axi_sram_burst_slave #(
  parameter int                ID_W       = 8,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MEM_AW     = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = 32'h0000_FFFF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_sram_burst_slave_if.slave axi,
  output logic                CS,
  output logic                OE,
  output logic [DATA_W/8-1:0] WEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  localparam int                BYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] SPAN     = LIMIT_ADDR - BASE_ADDR;
  localparam logic [MEM_AW-1:0] WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0]        B_FIXED  = 2'b00;
  localparam logic [1:0]        B_WRAP   = 2'b10;
  localparam logic [1:0]        RESP_OK  = 2'b00;
  localparam logic [1:0]        RESP_SLV = 2'b10;
  localparam logic [1:0]        RESP_DEC = 2'b11;

  typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_ISSUE, R_DATA} state_t;

  state_t            state_q, state_d;
  logic              rr_read_q, rr_read_d;   // 1: read wins a tie
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        beat_q, beat_d;
  logic              in_range_q, in_range_d;
  logic              len_err_q, len_err_d;
  logic              over_q, over_d;         // write beats past AWLEN

  // combinational outputs, mirrored onto the interface below
  logic              aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic [ID_W-1:0]   b_id, r_id;
  logic [1:0]        b_resp, r_resp;
  logic [DATA_W-1:0] r_data;

  logic              grant_w, grant_r;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   start_off;
  logic              start_in_range;
  logic              is_wrap;
  logic [MEM_AW-1:0] next_addr;
  logic              unused_sizes;

  // size is implied by the fixed 32-bit SRAM word
  assign unused_sizes = ^{axi.AWSIZE, axi.ARSIZE};

  assign is_wrap   = (burst_q == B_WRAP);
  assign next_addr = (burst_q == B_FIXED) ? addr_q : addr_q + WORD_ONE;

  // range decode on the start address of whichever side is being granted
  assign start_addr     = grant_w ? axi.AWADDR : axi.ARADDR;
  assign start_off      = {1'b0, start_addr} - {1'b0, BASE_ADDR};
  assign start_in_range = !start_off[ADDR_W] && (start_off[ADDR_W-1:0] <= SPAN);

  // state register and transaction context
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      rr_read_q  <= 1'b1;
      id_q       <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      in_range_q <= 1'b0;
      len_err_q  <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_read_q  <= rr_read_d;
      id_q       <= id_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      in_range_q <= in_range_d;
      len_err_q  <= len_err_d;
      over_q     <= over_d;
    end
  end

  // next-state, arbitration, AXI channel and SRAM pin decode
  always_comb begin
    state_d    = state_q;
    rr_read_d  = rr_read_q;
    id_d       = id_q;
    len_d      = len_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    in_range_d = in_range_q;
    len_err_d  = len_err_q;
    over_d     = over_q;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_id       = '0;
    b_resp     = RESP_OK;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    r_id       = '0;
    r_data     = '0;
    r_resp     = RESP_OK;
    r_last     = 1'b0;
    CS         = 1'b0;
    OE         = 1'b0;
    WEB        = '1;
    A          = '0;
    DI         = '0;

    case (state_q)
      IDLE: begin
        // gated by reset so READY stays low while ARESETn is asserted
        grant_r  = ARESETn && axi.ARVALID && (!axi.AWVALID || rr_read_q);
        grant_w  = ARESETn && axi.AWVALID && (!axi.ARVALID || !rr_read_q);
        aw_ready = grant_w;
        ar_ready = grant_r;
        if (grant_w || grant_r) begin
          addr_d     = start_addr[MEM_AW+1:2];
          beat_d     = '0;
          in_range_d = start_in_range;
          len_err_d  = 1'b0;
          over_d     = 1'b0;
          rr_read_d  = grant_w;   // the other side wins the next tie
        end
        if (grant_w) begin
          id_d    = axi.AWID;
          len_d   = axi.AWLEN;
          burst_d = axi.AWBURST;
          state_d = W_DATA;
        end else if (grant_r) begin
          id_d    = axi.ARID;
          len_d   = axi.ARLEN;
          burst_d = axi.ARBURST;
          state_d = R_ISSUE;
        end
      end

      W_DATA: begin
        w_ready = 1'b1;
        CS      = axi.WVALID;
        A       = addr_q;
        DI      = axi.WDATA;
        if (axi.WVALID && in_range_q && !over_q) begin
          WEB = ~axi.WSTRB;
        end
        if (axi.WVALID) begin
          addr_d = next_addr;
          if (axi.WLAST) begin
            len_err_d = len_err_q || over_q || (beat_q != len_q);
            state_d   = W_RESP;
          end else if (beat_q == len_q) begin
            // master is sending more beats than announced: swallow them
            over_d    = 1'b1;
            len_err_d = 1'b1;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end

      W_RESP: begin
        b_valid = 1'b1;
        b_id    = id_q;
        if (!in_range_q) begin
          b_resp = RESP_DEC;
        end else if (len_err_q || is_wrap) begin
          b_resp = RESP_SLV;
        end
        if (axi.BREADY) begin
          state_d = IDLE;
        end
      end

      R_ISSUE: begin
        CS      = 1'b1;
        OE      = 1'b1;
        A       = addr_q;
        state_d = R_DATA;
      end

      R_DATA: begin
        // SRAM is left deselected so DO holds through an RREADY stall
        r_valid = 1'b1;
        r_id    = id_q;
        r_last  = (beat_q == len_q);
        r_data  = in_range_q ? DO : '0;
        if (!in_range_q) begin
          r_resp = RESP_DEC;
        end else if (is_wrap) begin
          r_resp = RESP_SLV;
        end
        if (axi.RREADY) begin
          if (r_last) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 4'd1;
            state_d = R_ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign axi.AWREADY = aw_ready;
  assign axi.WREADY  = w_ready;
  assign axi.BVALID  = b_valid;
  assign axi.BID     = b_id;
  assign axi.BRESP   = b_resp;
  assign axi.ARREADY = ar_ready;
  assign axi.RVALID  = r_valid;
  assign axi.RID     = r_id;
  assign axi.RDATA   = r_data;
  assign axi.RRESP   = r_resp;
  assign axi.RLAST   = r_last;

endmodule

// File: tb/tb_axi_sram_burst_slave.sv
// Directed scoreboard bench for axi_sram_burst_slave: stimulus pushes the
// expected SRAM writes, B responses and R beats; negedge monitors pop and
// compare as the DUT presents them.
module tb_axi_sram_burst_slave;

  logic        ACLK;
  logic        ARESETn;
  logic        CS, OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI, DO;

  axi_sram_burst_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32)) axi ();

  axi_sram_burst_slave #(
    .ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14),
    .BASE_ADDR(32'h0000_0000), .LIMIT_ADDR(32'h0000_FFFF)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // SRAM macro model
  logic [31:0] mem [0:16383];
  always @(posedge ACLK) begin
    if (CS) begin
      for (int b = 0; b < 4; b++) begin
        if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
      end
      if (OE) DO <= mem[A];
    end
  end

  typedef struct { logic [13:0] a; logic [3:0] web; logic [31:0] di; } wr_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

  wr_t wr_q[$];
  b_t  b_q[$];
  r_t  r_q[$];
  wr_t wr_e;
  b_t  b_e;
  r_t  r_e;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic exp_wr(input logic [13:0] a, input logic [3:0] web, input logic [31:0] di);
    wr_q.push_back('{a: a, web: web, di: di});
  endtask
  task automatic exp_b(input logic [7:0] id, input logic [1:0] resp);
    b_q.push_back('{id: id, resp: resp});
  endtask
  task automatic exp_r(input logic [7:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    r_q.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  // monitor: SRAM write strobes
  always @(negedge ACLK) begin
    if (ARESETn && CS && (WEB != 4'hF)) begin
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL sram_write: unexpected write A=%0h WEB=%0h DI=%0h", A, WEB, DI);
      end else begin
        wr_e = wr_q.pop_front();
        check("sram_A", A, wr_e.a);
        check("sram_WEB", WEB, wr_e.web);
        check("sram_DI", DI, wr_e.di);
        $display("sram write A=%0h WEB=%0h DI=%0h", A, WEB, DI);
      end
    end
  end

  // monitor: write responses
  always @(negedge ACLK) begin
    if (ARESETn && axi.BVALID && axi.BREADY) begin
      if (b_q.size() == 0) begin
        checks++;
        $display("FAIL bresp: unexpected response BID=%0h BRESP=%0h", axi.BID, axi.BRESP);
      end else begin
        b_e = b_q.pop_front();
        check("BID", axi.BID, b_e.id);
        check("BRESP", axi.BRESP, b_e.resp);
        $display("B  id=%0h resp=%0h", axi.BID, axi.BRESP);
      end
    end
  end

  // monitor: read beats, plus RDATA stability while stalled
  always @(negedge ACLK) begin
    if (ARESETn && axi.RVALID) begin
      if (axi.RREADY) begin
        if (r_q.size() == 0) begin
          checks++;
          $display("FAIL rbeat: unexpected beat RID=%0h RDATA=%0h", axi.RID, axi.RDATA);
        end else begin
          r_e = r_q.pop_front();
          check("RID", axi.RID, r_e.id);
          check("RDATA", axi.RDATA, r_e.data);
          check("RRESP", axi.RRESP, r_e.resp);
          check("RLAST", axi.RLAST, r_e.last);
          $display("R  id=%0h data=%0h resp=%0h last=%0b", axi.RID, axi.RDATA, axi.RRESP, axi.RLAST);
        end
      end else if (r_q.size() != 0) begin
        check("rdata_hold", axi.RDATA, r_q[0].data);
      end
    end
  end

  task automatic aw_drive(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWVALID = 1'b1;
  endtask
  task automatic ar_drive(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARBURST = burst; axi.ARVALID = 1'b1;
  endtask

  task automatic aw_wait();
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!axi.AWREADY && n < 50);
    if (!axi.AWREADY) timeout("awready");
    @(posedge ACLK); #1 axi.AWVALID = 1'b0;
  endtask
  task automatic ar_wait();
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!axi.ARREADY && n < 50);
    if (!axi.ARREADY) timeout("arready");
    @(posedge ACLK); #1 axi.ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n = 0;
    axi.WDATA = d; axi.WSTRB = strb; axi.WLAST = last; axi.WVALID = 1'b1;
    do begin @(negedge ACLK); n++; end while (!axi.WREADY && n < 50);
    if (!axi.WREADY) timeout("wready");
    @(posedge ACLK); #1 axi.WVALID = 1'b0; axi.WLAST = 1'b0;
  endtask

  task automatic b_recv();
    int n = 0;
    axi.BREADY = 1'b1;
    do begin @(negedge ACLK); n++; end while (!axi.BVALID && n < 50);
    if (!axi.BVALID) timeout("bvalid");
    @(posedge ACLK); #1 axi.BREADY = 1'b0;
  endtask

  // accept n read beats, holding RREADY low for stall_cyc cycles on beat stall_beat
  task automatic r_recv(input int nbeats, input int stall_beat, input int stall_cyc);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      while (!axi.RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      if (!axi.RVALID) begin timeout("rvalid"); return; end
      if (i == stall_beat) repeat (stall_cyc) begin @(posedge ACLK); #1; end
      axi.RREADY = 1'b1;
      @(posedge ACLK); #1 axi.RREADY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    DO = '0;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;
    ARESETn = 1'b0;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", axi.AWREADY, 0);
    check("rst_arready", axi.ARREADY, 0);
    check("rst_wready", axi.WREADY, 0);
    check("rst_bvalid", axi.BVALID, 0);
    check("rst_rvalid", axi.RVALID, 0);
    check("rst_cs_oe", {CS, OE}, 0);
    check("rst_web", WEB, 4'hF);
    check("rst_a_di", {A, DI}, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // single write then read with latency check
    exp_wr(14'h0004, 4'h0, 32'hDEADBEEF); exp_b(8'h01, 2'b00);
    aw_drive(8'h01, 32'h10, 4'd0, 2'b01); aw_wait();
    w_send(32'hDEADBEEF, 4'hF, 1'b1); b_recv();
    exp_r(8'h02, 32'hDEADBEEF, 2'b00, 1'b1);
    ar_drive(8'h02, 32'h10, 4'd0, 2'b01); ar_wait();
    check("rvalid_early", axi.RVALID, 0);
    @(posedge ACLK); #1;
    check("rd_latency", axi.RVALID, 1);
    r_recv(1, -1, 0);

    // INCR burst wrapping the word address, read back with a stall on beat 2
    for (int i = 0; i < 4; i++) exp_wr(14'h3FFE + 14'(i), 4'h0, 32'hA000_0000 + 32'(i));
    exp_b(8'h03, 2'b00);
    aw_drive(8'h03, 32'h0000_FFF8, 4'd3, 2'b01); aw_wait();
    for (int i = 0; i < 4; i++) w_send(32'hA000_0000 + 32'(i), 4'hF, i == 3);
    b_recv();
    for (int i = 0; i < 4; i++) exp_r(8'h04, 32'hA000_0000 + 32'(i), 2'b00, i == 3);
    ar_drive(8'h04, 32'h0000_FFF8, 4'd3, 2'b01); ar_wait();
    r_recv(4, 1, 3);

    // byte strobes
    exp_wr(14'h0008, 4'h0, 32'h11223344); exp_b(8'h05, 2'b00);
    aw_drive(8'h05, 32'h20, 4'd0, 2'b01); aw_wait();
    w_send(32'h11223344, 4'hF, 1'b1); b_recv();
    exp_wr(14'h0008, 4'b1010, 32'hAABBCCDD); exp_b(8'h06, 2'b00);
    aw_drive(8'h06, 32'h20, 4'd0, 2'b01); aw_wait();
    w_send(32'hAABBCCDD, 4'b0101, 1'b1); b_recv();
    exp_r(8'h07, 32'h11BB33DD, 2'b00, 1'b1);
    ar_drive(8'h07, 32'h20, 4'd0, 2'b01); ar_wait();
    r_recv(1, -1, 0);

    // out of range: no SRAM writes, DECERR, zero read data
    exp_b(8'h08, 2'b11);
    aw_drive(8'h08, 32'h0001_0000, 4'd1, 2'b01); aw_wait();
    w_send(32'h12345678, 4'hF, 1'b0); w_send(32'h9ABCDEF0, 4'hF, 1'b1); b_recv();
    exp_r(8'h09, 32'h0, 2'b11, 1'b0); exp_r(8'h09, 32'h0, 2'b11, 1'b1);
    ar_drive(8'h09, 32'h0001_0000, 4'd1, 2'b01); ar_wait();
    r_recv(2, -1, 0);

    // WLAST early: AWLEN 2, WLAST on beat 1
    exp_wr(14'h000C, 4'h0, 32'h1111_1111); exp_wr(14'h000D, 4'h0, 32'h2222_2222); exp_b(8'h0A, 2'b10);
    aw_drive(8'h0A, 32'h30, 4'd2, 2'b01); aw_wait();
    w_send(32'h1111_1111, 4'hF, 1'b0); w_send(32'h2222_2222, 4'hF, 1'b1); b_recv();

    // WLAST late: AWLEN 0, two beats; the extra beat is not written
    exp_wr(14'h000D, 4'h0, 32'h3333_3333); exp_b(8'h0B, 2'b10);
    aw_drive(8'h0B, 32'h34, 4'd0, 2'b01); aw_wait();
    w_send(32'h3333_3333, 4'hF, 1'b0); w_send(32'h4444_4444, 4'hF, 1'b1); b_recv();

    // FIXED burst: address constant
    for (int i = 0; i < 3; i++) exp_wr(14'h0010, 4'h0, 32'hF000_0000 + 32'(i));
    exp_b(8'h0C, 2'b00);
    aw_drive(8'h0C, 32'h40, 4'd2, 2'b00); aw_wait();
    for (int i = 0; i < 3; i++) w_send(32'hF000_0000 + 32'(i), 4'hF, i == 2);
    b_recv();

    // WRAP burst is written as INCR but flagged SLVERR
    exp_wr(14'h0018, 4'h0, 32'h5A5A_5A5A); exp_b(8'h0D, 2'b10);
    aw_drive(8'h0D, 32'h60, 4'd0, 2'b10); aw_wait();
    w_send(32'h5A5A_5A5A, 4'hF, 1'b1); b_recv();

    // arbitration from a fresh reset: read wins first tie, write the second
    ARESETn = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;
    exp_r(8'h13, 32'hDEADBEEF, 2'b00, 1'b1);
    ar_drive(8'h13, 32'h10, 4'd0, 2'b01);
    aw_drive(8'h14, 32'h50, 4'd0, 2'b01);
    @(negedge ACLK);
    check("arb1_arready", axi.ARREADY, 1);
    check("arb1_awready", axi.AWREADY, 0);
    @(posedge ACLK); #1 axi.ARVALID = 1'b0;
    @(negedge ACLK);
    check("busy_awready", axi.AWREADY, 0);
    r_recv(1, -1, 0);
    exp_r(8'h15, 32'h11BB33DD, 2'b00, 1'b1);
    ar_drive(8'h15, 32'h20, 4'd0, 2'b01);
    @(negedge ACLK);
    check("arb2_awready", axi.AWREADY, 1);
    check("arb2_arready", axi.ARREADY, 0);
    @(posedge ACLK); #1 axi.AWVALID = 1'b0;
    exp_wr(14'h0014, 4'h0, 32'h5566_7788); exp_b(8'h14, 2'b00);
    w_send(32'h5566_7788, 4'hF, 1'b1); b_recv();
    ar_wait();
    r_recv(1, -1, 0);

    // reset in the middle of a read burst
    for (int i = 0; i < 4; i++) exp_r(8'h16, 32'hA000_0000 + 32'(i), 2'b00, i == 3);
    ar_drive(8'h16, 32'h0000_FFF8, 4'd3, 2'b01); ar_wait();
    r_recv(1, -1, 0);
    n = 0;
    while (!axi.RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    check("midburst_rvalid", axi.RVALID, 1);
    ARESETn = 1'b0;
    #1;
    check("midrst_rvalid", axi.RVALID, 0);
    check("midrst_web", WEB, 4'hF);
    check("midrst_cs", CS, 0);
    r_q.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    exp_r(8'h17, 32'h11BB33DD, 2'b00, 1'b1);
    ar_drive(8'h17, 32'h20, 4'd0, 2'b01); ar_wait();
    r_recv(1, -1, 0);

    repeat (4) @(posedge ACLK);
    #1;
    check("wr_q_drained", wr_q.size(), 0);
    check("b_q_drained", b_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
